// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: byte-serial NBYTES-wide add (optional subtract) on a shared 8-bit ripple adder
//   clk, rst (async, active-high)
//   start_valid/start_ready, op_a, op_b, op_cin : operand request (accepted in IDLE only)
//   add_a, add_b, add_cin -> adder ; add_sum, add_cout <- adder
//   res_valid/res_ready, result, res_cout        : result handshake, held stable in DONE
//   busy                                         : high in RUN or DONE
//   ADD_SEQ_SUB_EN defined adds input op_sub (1 = two's-complement A-B, res_cout=1 means no borrow)
module add_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  op_cin,
`ifdef ADD_SEQ_SUB_EN
    input  logic                  op_sub,
`endif
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [8*NBYTES-1:0]   result,
    output logic                  res_cout,
    output logic                  busy
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  res_reg;
    logic          sub;
    logic          run;

`ifdef ADD_SEQ_SUB_EN
    assign sub = op_sub;
`else
    assign sub = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    a_reg   <= op_a;
                    b_reg   <= sub ? ~op_b : op_b;
                    // subtract forces carry-in 1 to complete the two's complement
                    carry   <= sub | op_cin;
                    idx     <= '0;
                    res_reg <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    res_reg[8*idx +: 8] <= add_sum;
                    carry               <= add_cout;
                    if (idx == IW'(NBYTES-1)) state <= DONE;
                    else idx <= idx + 1'b1;
                end
                DONE: if (res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // adder operands come only from registers, never straight from op_*
    assign run         = state == RUN;
    assign add_a       = run ? a_reg[8*idx +: 8] : 8'h00;
    assign add_b       = run ? b_reg[8*idx +: 8] : 8'h00;
    assign add_cin     = run & carry;
    assign start_ready = state == IDLE;
    assign res_valid   = state == DONE;
    assign busy        = state != IDLE;
    assign result      = res_reg;
    assign res_cout    = carry;
endmodule
